// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: raw active-low pushbuttons in, grid cursor and select strobe out
interface cursor_ctrl_if;
  logic key_up_n;
  logic key_down_n;
  logic key_left_n;
  logic key_right_n;
  logic key_sel_n;
  logic [2:0] i_actual;
  logic [2:0] j_actual;
  logic sel_pulse;
  logic [2:0] sel_i;
  logic [2:0] sel_j;
  modport master (
    output key_up_n, key_down_n, key_left_n, key_right_n, key_sel_n,
    input  i_actual, j_actual, sel_pulse, sel_i, sel_j
  );
  modport slave (
    input  key_up_n, key_down_n, key_left_n, key_right_n, key_sel_n,
    output i_actual, j_actual, sel_pulse, sel_i, sel_j
  );
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: debounced pushbuttons move a wrapping grid cursor and strobe select.
// Define AUTO_REPEAT_EN to add hold-to-repeat moves on the direction keys.
module cursor_ctrl #(
  parameter int ROWS            = 8,
  parameter int COLS            = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic clk,
  input logic rst,
  cursor_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] I_MAX = 3'(ROWS - 1);
  localparam logic [2:0] J_MAX = 3'(COLS - 1);
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} dir_state_t;
`else
  typedef enum logic [0:0] {IDLE, HELD} dir_state_t;
`endif
  logic [4:0] raw, s1, s2, deb, deb_d, press;
  logic [3:0] mv;
  logic [2:0] i_q, j_q, i_nx, j_nx, sel_i_q, sel_j_q;
  logic sel_q;
  // bit order: 0 up, 1 down, 2 left, 3 right, 4 select; 1 means pressed
  assign raw = ~{bus.key_sel_n, bus.key_right_n, bus.key_left_n, bus.key_down_n, bus.key_up_n};
  assign press = deb & ~deb_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      deb_d <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_d <= deb;
    end
  end
  for (genvar k = 0; k < 5; k++) begin : g_deb
    logic [DW-1:0] cnt;
    logic deb_r;
    assign deb[k] = deb_r;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        deb_r <= 1'b0;
      end else if (s2[k] == deb_r) begin
        cnt <= '0;
      end else if (cnt == D_LAST) begin
        cnt <= '0;
        deb_r <= ~deb_r;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_dir
    dir_state_t st, st_nx;
    logic rep;
`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] hcnt, hcnt_nx;
    always_ff @(posedge clk) begin
      st <= rst ? IDLE : st_nx;
      hcnt <= rst ? '0 : hcnt_nx;
    end
`else
    always_ff @(posedge clk) begin
      st <= rst ? IDLE : st_nx;
    end
`endif
    always_comb begin
      st_nx = st;
      rep = 1'b0;
`ifdef AUTO_REPEAT_EN
      hcnt_nx = '0;
`endif
      if (!deb[k]) begin
        st_nx = IDLE;
      end else if (st == IDLE) begin
        st_nx = press[k] ? HELD : IDLE;
`ifdef AUTO_REPEAT_EN
      end else if (st == HELD) begin
        rep = (hcnt == DLY_LAST);
        st_nx = rep ? REPEAT : HELD;
        hcnt_nx = rep ? '0 : hcnt + 1'b1;
      end else begin
        rep = (hcnt == PER_LAST);
        hcnt_nx = rep ? '0 : hcnt + 1'b1;
`endif
      end
    end
    assign mv[k] = (press[k] && st == IDLE) || rep;
  end
  // one move per cycle, up > down > left > right
  always_comb begin
    i_nx = i_q;
    j_nx = j_q;
    if (mv[0]) i_nx = (i_q == 3'd0) ? I_MAX : i_q - 3'd1;
    else if (mv[1]) i_nx = (i_q == I_MAX) ? 3'd0 : i_q + 3'd1;
    else if (mv[2]) j_nx = (j_q == 3'd0) ? J_MAX : j_q - 3'd1;
    else if (mv[3]) j_nx = (j_q == J_MAX) ? 3'd0 : j_q + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      sel_q <= 1'b0;
      sel_i_q <= '0;
      sel_j_q <= '0;
    end else begin
      i_q <= i_nx;
      j_q <= j_nx;
      sel_q <= press[4];
      if (press[4]) begin
        sel_i_q <= i_q;
        sel_j_q <= j_q;
      end
    end
  end
  assign bus.i_actual = i_q;
  assign bus.j_actual = j_q;
  assign bus.sel_pulse = sel_q;
  assign bus.sel_i = sel_i_q;
  assign bus.sel_j = sel_j_q;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: vector table, hand sequences and random keys against a sample-history model
module tb_cursor_ctrl;
  localparam int D = 4;
  typedef struct {
    logic [4:0] keys;
    int exp_i;
    int exp_j;
    int exp_i5;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] keys;
  int checks = 0;
  int errors = 0;
  int mi, mj, mi5, msi, msj;
  bit mp;
  bit dl0[5], dl1[5], mdeb[5], pend[5];
  bit hist[5][$];
  vec_t tbl[12];
  always #5 clk = ~clk;
  cursor_ctrl_if bus();
  cursor_ctrl_if bus5();
  assign bus.key_up_n = ~keys[0];
  assign bus.key_down_n = ~keys[1];
  assign bus.key_left_n = ~keys[2];
  assign bus.key_right_n = ~keys[3];
  assign bus.key_sel_n = ~keys[4];
  assign bus5.key_up_n = ~keys[0];
  assign bus5.key_down_n = ~keys[1];
  assign bus5.key_left_n = ~keys[2];
  assign bus5.key_right_n = ~keys[3];
  assign bus5.key_sel_n = ~keys[4];
  cursor_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  cursor_ctrl #(.ROWS(5), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave));
  // a level is accepted once the last D synchronised samples all disagree with the accepted level
  always @(posedge clk) begin
    bit [4:0] ev;
    bit flip, lvl;
    if (rst) begin
      mi = 0; mj = 0; mi5 = 0; msi = 0; msj = 0; mp = 0;
      for (int k = 0; k < 5; k++) begin
        dl0[k] = 0; dl1[k] = 0; mdeb[k] = 0; pend[k] = 0;
        hist[k].delete();
      end
    end else begin
      for (int k = 0; k < 5; k++) ev[k] = pend[k];
      mp = ev[4];
      if (ev[4]) begin
        msi = mi;
        msj = mj;
      end
      if (ev[0]) begin mi = (mi + 7) % 8; mi5 = (mi5 + 4) % 5; end
      else if (ev[1]) begin mi = (mi + 1) % 8; mi5 = (mi5 + 1) % 5; end
      else if (ev[2]) mj = (mj + 7) % 8;
      else if (ev[3]) mj = (mj + 1) % 8;
      for (int k = 0; k < 5; k++) begin
        lvl = dl1[k];
        dl1[k] = dl0[k];
        dl0[k] = keys[k];
        hist[k].push_back(lvl);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        pend[k] = 0;
        if (hist[k].size() == D) begin
          flip = 1;
          foreach (hist[k][n]) if (hist[k][n] == mdeb[k]) flip = 0;
          if (flip) begin
            mdeb[k] = !mdeb[k];
            hist[k].delete();
            pend[k] = mdeb[k];
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cmp_model();
    chk("model_i", 32'(bus.i_actual), 32'(mi));
    chk("model_j", 32'(bus.j_actual), 32'(mj));
    chk("model_i5", 32'(bus5.i_actual), 32'(mi5));
    chk("model_pulse", 32'(bus.sel_pulse), 32'(mp));
    chk("model_sel_i", 32'(bus.sel_i), 32'(msi));
    chk("model_sel_j", 32'(bus.sel_j), 32'(msj));
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask
  initial begin
    int pulses;
    tbl[0]  = '{5'b00001, 7, 1, 4};
    tbl[1]  = '{5'b00100, 7, 0, 4};
    tbl[2]  = '{5'b00100, 7, 7, 4};
    tbl[3]  = '{5'b01000, 7, 0, 4};
    tbl[4]  = '{5'b00010, 0, 0, 0};
    tbl[5]  = '{5'b00010, 1, 0, 1};
    tbl[6]  = '{5'b00010, 2, 0, 2};
    tbl[7]  = '{5'b00010, 3, 0, 3};
    tbl[8]  = '{5'b01000, 3, 1, 3};
    tbl[9]  = '{5'b01000, 3, 2, 3};
    tbl[10] = '{5'b01000, 3, 3, 3};
    tbl[11] = '{5'b00101, 2, 3, 2};
    keys = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i", 32'(bus.i_actual), 0);
    chk("rst_j", 32'(bus.j_actual), 0);
    chk("rst_pulse", 32'(bus.sel_pulse), 0);
    chk("rst_sel_i", 32'(bus.sel_i), 0);
    chk("rst_sel_j", 32'(bus.sel_j), 0);
    rst = 1'b0;
    cyc(3);
    keys[3] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      cmp_model();
      if (n == 6) chk("latency_before", 32'(bus.j_actual), 0);
      if (n == 7) chk("latency_after", 32'(bus.j_actual), 1);
    end
    keys[3] = 1'b0;
    cyc(12);
    chk("no_move_on_release", 32'(bus.j_actual), 1);
    keys[1] = 1'b1;
    cyc(3);
    keys[1] = 1'b0;
    cyc(10);
    chk("glitch_i", 32'(bus.i_actual), 0);
    for (int n = 0; n < 3; n++) begin
      keys[1] = 1'b1;
      cyc(3);
      keys[1] = 1'b0;
      cyc(3);
    end
    cyc(8);
    chk("bounce_i", 32'(bus.i_actual), 0);
    for (int n = 0; n < 12; n++) begin
      keys = tbl[n].keys;
      cyc(8);
      keys = '0;
      cyc(10);
      chk($sformatf("tbl%0d_i", n), 32'(bus.i_actual), 32'(tbl[n].exp_i));
      chk($sformatf("tbl%0d_j", n), 32'(bus.j_actual), 32'(tbl[n].exp_j));
      chk($sformatf("tbl%0d_i5", n), 32'(bus5.i_actual), 32'(tbl[n].exp_i5));
    end
    keys = 5'b10010;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      cmp_model();
      if (bus.sel_pulse) begin
        pulses++;
        chk("sel_i_premove", 32'(bus.sel_i), 2);
        chk("sel_j_premove", 32'(bus.sel_j), 3);
        chk("sel_move_i", 32'(bus.i_actual), 3);
      end
    end
    chk("sel_pulse_count", 32'(pulses), 1);
    keys = '0;
    cyc(10);
    for (int n = 0; n < 200; n++) begin
      keys = 5'($urandom);
      cyc(int'($urandom_range(1, 10)));
    end
    keys = '0;
    cyc(12);
    keys[2] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midhold_rst_j", 32'(bus.j_actual), 0);
    chk("midhold_rst_i", 32'(bus.i_actual), 0);
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 6) chk("rehold_before", 32'(bus.j_actual), 0);
      if (n == 7) chk("rehold_after", 32'(bus.j_actual), 7);
`ifdef AUTO_REPEAT_EN
      if (n == 17) chk("repeat_first", 32'(bus.j_actual), 6);
      if (n == 20) chk("repeat_next", 32'(bus.j_actual), 5);
`else
      if (n == 20) chk("held_terminal", 32'(bus.j_actual), 7);
`endif
    end
    keys = '0;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
